// File: rtl/pending_index_encoder.sv
// pending_index_encoder
//   Collects pending entries in a 32-bit register and presents one binary index
//   at a time on a valid/ready output, one accept per cycle.
//   Optional feature: define PENDING_INDEX_ROUND_ROBIN_EN to search from the
//   entry after the last accepted one instead of fixed lowest-index priority.
module pending_index_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_en,
    input  logic [31:0] set_mask,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_index,
    output logic [5:0]  pending_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] p_q, p_d;
    logic [4:0]  idx_q, idx_d;
    logic [5:0]  cnt_q, cnt_d;

    logic        accept;
    logic [31:0] clear_mask;
    logic [31:0] set_bits;
    logic [31:0] p_upd;
    logic [4:0]  idle_start;
    logic [4:0]  next_start;

    // Lowest set bit of vec at or after start, wrapping 31->0.
    // The descending loop lets the smallest offset overwrite larger ones.
    function automatic logic [4:0] pick_index(input logic [31:0] vec, input logic [4:0] start);
        logic [4:0] sel;
        logic [4:0] k;
        sel = start;
        for (int i = 31; i >= 0; i--) begin
            k = start + 5'(i);
            if (vec[k]) sel = k;
        end
        return sel;
    endfunction

    // Number of ones in a 32-bit vector (0..32).
    function automatic logic [5:0] popcount(input logic [31:0] vec);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < 32; i++) begin
            c = c + 6'(vec[i]);
        end
        return c;
    endfunction

`ifdef PENDING_INDEX_ROUND_ROBIN_EN
    logic [4:0] ptr_q, ptr_d;

    // Search origins: idle search resumes after the last accept, a back-to-back
    // search starts just after the entry being accepted now.
    always_comb begin
        idle_start = ptr_q;
        next_start = idx_q + 5'd1;
        ptr_d      = ptr_q;
        if (accept) ptr_d = idx_q + 5'd1;
    end

    // Rotation pointer; only moves on an accept.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= 5'd0;
        else       ptr_q <= ptr_d;
    end
`else
    // Fixed priority: every search starts at entry 0.
    always_comb begin
        idle_start = 5'd0;
        next_start = 5'd0;
    end
`endif

    // Pending-register update, selection and state transitions.
    always_comb begin
        accept     = (state_q == PRESENT) && out_ready;
        clear_mask = accept ? (32'd1 << idx_q) : 32'd0;
        set_bits   = set_en ? set_mask : 32'd0;
        // Set is ORed after the clear so a same-cycle set of the accepted bit wins.
        p_upd      = (p_q & ~clear_mask) | set_bits;

        p_d     = p_upd;
        state_d = state_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (p_q != 32'd0) begin
                    idx_d   = pick_index(p_q, idle_start);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (accept) begin
                    if (p_upd != 32'd0) idx_d = pick_index(p_upd, next_start);
                    else                state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            p_d     = 32'd0;
            state_d = IDLE;
        end

        cnt_d = popcount(p_d);
    end

    // State registers; reset overrides flush, sets and accepts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= 32'd0;
            idx_q   <= 5'd0;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid   = (state_q == PRESENT);
    assign out_index   = idx_q;
    assign pending_cnt = cnt_q;

endmodule

// File: doc/pending_index_encoder.md
PENDING_INDEX_ENCODER -- requirements
Module: pending_index_encoder

Interface
REQ-001 SHALL have parameters: none (fixed 32 entries, 5-bit index).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: set_en  in  1  qualifies set_mask.
REQ-005 SHALL have ports: set_mask  in  32  bits to mark pending (bit k = entry k).
REQ-006 SHALL have ports: flush  in  1  clear all pending state.
REQ-007 SHALL have ports: out_valid  out  1  out_index holds a pending entry.
REQ-008 SHALL have ports: out_ready  in  1  consumer accepts out_index.
REQ-009 SHALL have ports: out_index  out  5  binary index of presented entry.
REQ-010 SHALL have ports: pending_cnt  out  6  popcount of pending register (0..32).

Function
REQ-011 SHALL hold a 32-bit pending register P; set_en=1 ORs set_mask into P at the clock edge.
REQ-012 SHALL implement states IDLE (out_valid=0) and PRESENT (out_valid=1).
REQ-013 IDLE: if P!=0, SHALL register the selected index (REQ-017) into out_index and enter PRESENT; else stay IDLE.
REQ-014 PRESENT, out_ready=0: out_index and out_valid SHALL hold unchanged regardless of set_en activity.
REQ-015 PRESENT, out_ready=1 (accept): SHALL clear P[out_index]; if the post-update P (cleared, plus same-cycle sets) is nonzero, SHALL register the next selected index and stay PRESENT (back-to-back, one accept per cycle); else return to IDLE.
REQ-016 Latency: set_en in cycle N SHALL update P at N+1; out_valid SHALL rise at N+2 when starting from IDLE.
REQ-017 Selection SHALL pick the lowest-numbered set bit of the candidate vector (fixed priority), unless modified by REQ-024.
REQ-018 Same-cycle set and accept-clear of the same bit: set SHALL win (bit remains pending and is re-presented later).
REQ-019 flush=1 SHALL clear P, force IDLE, drive out_valid=0 next cycle; flush SHALL override same-cycle set_en and accept.
REQ-020 pending_cnt SHALL be the registered popcount of P, updated in the same cycle as P.
REQ-021 set_mask bits already pending SHALL have no additional effect (no count overflow, saturates at 32 entries by construction).

Reset
REQ-022 reset=1 at a clock edge SHALL set P=0, state=IDLE, out_valid=0, out_index=0, pending_cnt=0, and the rotation pointer (REQ-024) to 0; reset SHALL override flush, set_en and accept, including mid-handshake.

Configuration
REQ-023 Macro SHALL be named PENDING_INDEX_ROUND_ROBIN_EN.
REQ-024 Defined: selection SHALL search starting at (last accepted index + 1) mod 32, wrapping 31->0; pointer updates only on accept. Undefined: fixed lowest-index priority per REQ-017, no pointer register.

Verification
REQ-025 Reset, then set_en=1 set_mask=0x0000_0000 -> out_valid stays 0, pending_cnt=0.
REQ-026 set_mask=0x8000_0011 once, out_ready=1 continuously -> out_valid rises 2 cycles later, out_index 0,4,31 on consecutive cycles, then out_valid=0, pending_cnt 3,2,1,0.
REQ-027 P=0x0000_0006, out_ready=0 for 5 cycles while set_mask=0x1 pulsed -> out_index held at 1 throughout; after out_ready=1, fixed mode next index 0, round-robin mode next index 2.
REQ-028 Presenting index 3, accept with same-cycle set_mask=0x8 -> bit 3 stays pending, pending_cnt unchanged, index 3 presented again later.
REQ-029 P=0xFFFF_FFFF, pending_cnt=32, flush=1 with set_en=1 set_mask=0x1 -> next cycle P=0, pending_cnt=0, out_valid=0.
REQ-030 Reset asserted while PRESENT with out_ready=1 -> next cycle all outputs 0, pending entries lost.
